// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 control unit.
// Holds the FSM state encoding, base opcodes, ALU operation codes,
// ALU decode modes and datapath mux-select encodings.
package rv32_ctrl_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned SEL_W      = 2;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  // Base opcodes (instruction bits [6:0])
  localparam logic [OPCODE_W-1:0] OP_R      = 7'h33;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'h13;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'h03;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'h67;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'h37;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'h17;

  // ALU operation codes
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd9;

  // How the ALU decoder interprets funct3/funct7b5
  localparam logic [1:0] MODE_ADD = 2'd0;  // forced add (fetch/address)
  localparam logic [1:0] MODE_R   = 2'd1;  // register-register op
  localparam logic [1:0] MODE_I   = 2'd2;  // register-immediate op
  localparam logic [1:0] MODE_BR  = 2'd3;  // branch compare

  // Datapath mux selects
  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_RS2    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEM      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU      = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMM      = 2'b11;

  // Branch outcome from the ALU zero flag: bit 0 inverts the sense,
  // bit 2 selects the compare (SLT/SLTU) family whose "true" is non-zero.
  function automatic logic branch_taken(input logic zero, input logic [2:0] f3);
    return zero ^ f3[0] ^ f3[2];
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode.
// Ports: mode (MODE_* from the package), funct3, funct7b5 -> alu_ctrl.
module alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl
);

  // funct7b5 only distinguishes SUB for register ops and SRA for both shift forms
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (mode)
      MODE_R, MODE_I: begin
        case (funct3)
          3'b000:  alu_ctrl = ((mode == MODE_R) && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      MODE_BR: begin
        case (funct3[2:1])
          2'b10:   alu_ctrl = ALU_SLT;
          2'b11:   alu_ctrl = ALU_SLTU;
          default: alu_ctrl = ALU_SUB;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM.
// Inputs : clk, reset (sync, active-high), opcode/funct3/funct7b5 from the
//          instruction register, zero_flag from the ALU, mem_ready.
// Outputs: write enables (pc/ir/old_pc/reg), mem_req/mem_write/adr_src,
//          pc_src, ALU operand/op selects, result_src, instr_retired, halted.
// Strobes are decoded from the state register; the fetch and memory
// handshakes and the branch decision use same-cycle inputs.
module multicycle_controller
  import rv32_ctrl_pkg::*;
#(
  parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       old_pc_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] alu_ctrl,
  output logic       instr_retired,
  output logic       halted
);

  state_t     state;
  logic       is_jalr;
  logic       decode_illegal;
  logic [1:0] alu_mode;

  alu_decoder u_alu_decoder (
    .mode     (alu_mode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (alu_ctrl)
  );

  // Unknown opcodes and the unused branch funct3 codes 010/011 are illegal
  always_comb begin
    decode_illegal = 1'b0;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: decode_illegal = 1'b0;
      OP_BRANCH: decode_illegal = (funct3[2:1] == 2'b01);
      default:   decode_illegal = 1'b1;
    endcase
  end

  // State sequencing; is_jalr remembers that S_EXEC_I is computing a jump target
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      is_jalr <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          is_jalr <= (opcode == OP_JALR);
          if (decode_illegal) begin
            state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          end else begin
            case (opcode)
              OP_R:               state <= S_EXEC_R;
              OP_IMM, OP_JALR:    state <= S_EXEC_I;
              OP_LOAD, OP_STORE:  state <= S_MEMADR;
              OP_BRANCH:          state <= S_BRANCH;
              OP_JAL:             state <= S_JAL;
              OP_LUI:             state <= S_LUI;
              OP_AUIPC:           state <= S_AUIPC;
              default:            state <= S_TRAP;
            endcase
          end
        end
        S_EXEC_R: state <= S_ALUWB;
        S_EXEC_I: state <= is_jalr ? S_JALR : S_ALUWB;
        S_MEMADR: state <= (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JAL,
        S_JALR, S_LUI, S_AUIPC: state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Per-state strobes and selects; reset masks every strobe in its own cycle
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    old_pc_write  = 1'b0;
    reg_write     = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALU_OUT;
    alu_mode      = MODE_ADD;
    instr_retired = 1'b0;
    halted        = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_FOUR;
        result_src   = RES_ALU;
        ir_write     = mem_ready;
        pc_write     = mem_ready;
        old_pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_a     = SRC_A_OLD_PC;
        alu_src_b     = SRC_B_IMM;
        instr_retired = decode_illegal && !TRAP_ON_ILLEGAL;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_mode  = MODE_R;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_mode  = is_jalr ? MODE_ADD : MODE_I;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWR: begin
        mem_req       = 1'b1;
        mem_write     = 1'b1;
        adr_src       = 1'b1;
        instr_retired = mem_ready;
      end
      S_MEMWB: begin
        reg_write     = 1'b1;
        result_src    = RES_MEM;
        instr_retired = 1'b1;
      end
      S_ALUWB, S_AUIPC: begin
        reg_write     = 1'b1;
        result_src    = RES_ALU_OUT;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        alu_mode      = MODE_BR;
        pc_src        = 1'b1;
        pc_write      = branch_taken(zero_flag, funct3);
        instr_retired = 1'b1;
      end
      // rd <= old_pc+4 via the live ALU, pc <= target held in alu_out
      S_JAL, S_JALR: begin
        alu_src_a     = SRC_A_OLD_PC;
        alu_src_b     = SRC_B_FOUR;
        result_src    = RES_ALU;
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
      end
      S_LUI: begin
        reg_write     = 1'b1;
        result_src    = RES_IMM;
        instr_retired = 1'b1;
      end
      S_TRAP: halted = 1'b1;
      default: ;
    endcase

    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      old_pc_write  = 1'b0;
      reg_write     = 1'b0;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      instr_retired = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Each test task drives one scenario cycle by cycle, pushes the expected
// control vector for that cycle into a scoreboard queue, and compares the
// popped entry against the DUT at the falling edge (masked to the fields
// that are defined in that cycle).
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       old_pc_write;
    logic       reg_write;
    logic       mem_req;
    logic       mem_write;
    logic       retired;
    logic       halted;
    logic       adr_src;
    logic       pc_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [3:0] alu;
  } obs_t;

  typedef struct {
    obs_t v;
    obs_t m;
  } exp_t;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_SRL = 4'd6,
                         A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;

  logic       clk = 1'b0;
  logic       reset, funct7b5, zero_flag, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;

  logic pc_write, ir_write, old_pc_write, reg_write, mem_req, mem_write;
  logic adr_src, pc_src, instr_retired, halted;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_ctrl;

  logic pc_write2, ir_write2, old_pc_write2, reg_write2, mem_req2, mem_write2;
  logic adr_src2, pc_src2, instr_retired2, halted2;
  logic [1:0] alu_src_a2, alu_src_b2, result_src2;
  logic [3:0] alu_ctrl2;

  obs_t obs;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign obs = {pc_write, ir_write, old_pc_write, reg_write, mem_req, mem_write,
                instr_retired, halted, adr_src, pc_src, alu_src_a, alu_src_b,
                result_src, alu_ctrl};

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .old_pc_write(old_pc_write),
    .reg_write(reg_write), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_ctrl(alu_ctrl),
    .instr_retired(instr_retired), .halted(halted)
  );

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .pc_write(pc_write2), .ir_write(ir_write2), .old_pc_write(old_pc_write2),
    .reg_write(reg_write2), .mem_req(mem_req2), .mem_write(mem_write2),
    .adr_src(adr_src2), .pc_src(pc_src2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .result_src(result_src2), .alu_ctrl(alu_ctrl2),
    .instr_retired(instr_retired2), .halted(halted2)
  );

  // ---------------- expected-vector builders ----------------
  function automatic exp_t e_idle();
    exp_t e;
    e.v = '0;
    e.m = '0;
    e.m.pc_write = 1'b1; e.m.ir_write = 1'b1; e.m.old_pc_write = 1'b1;
    e.m.reg_write = 1'b1; e.m.mem_req = 1'b1; e.m.mem_write = 1'b1;
    e.m.retired = 1'b1; e.m.halted = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_reset();
    exp_t e = e_idle();
    e.m.retired = 1'b0;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = e_idle();
    e.v.mem_req = 1'b1;
    e.v.ir_write = rdy; e.v.pc_write = rdy; e.v.old_pc_write = rdy;
    e.v.adr_src = 1'b0; e.m.adr_src = 1'b1;
    e.v.a = 2'b00; e.m.a = 2'b11;
    e.v.b = 2'b10; e.m.b = 2'b11;
    e.v.alu = A_ADD; e.m.alu = 4'hF;
    return e;
  endfunction

  function automatic exp_t e_decode();
    exp_t e = e_idle();
    e.v.a = 2'b01; e.m.a = 2'b11;
    e.v.b = 2'b01; e.m.b = 2'b11;
    e.v.alu = A_ADD; e.m.alu = 4'hF;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic imm_b, input logic [3:0] alu);
    exp_t e = e_idle();
    e.v.a = 2'b10; e.m.a = 2'b11;
    e.v.b = imm_b ? 2'b01 : 2'b00; e.m.b = 2'b11;
    e.v.alu = alu; e.m.alu = 4'hF;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic wr, input logic rdy);
    exp_t e = e_idle();
    e.v.mem_req = 1'b1;
    e.v.mem_write = wr;
    e.v.adr_src = 1'b1; e.m.adr_src = 1'b1;
    e.v.retired = wr & rdy;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [1:0] rs);
    exp_t e = e_idle();
    e.v.reg_write = 1'b1;
    e.v.retired = 1'b1;
    e.v.rs = rs; e.m.rs = 2'b11;
    return e;
  endfunction

  function automatic exp_t e_branch(input logic [3:0] alu, input logic taken);
    exp_t e = e_idle();
    e.v.alu = alu; e.m.alu = 4'hF;
    e.v.pc_write = taken;
    e.v.pc_src = 1'b1; e.m.pc_src = taken;
    e.v.retired = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_jump();
    exp_t e = e_idle();
    e.v.reg_write = 1'b1; e.v.pc_write = 1'b1; e.v.retired = 1'b1;
    e.v.rs = 2'b10; e.m.rs = 2'b11;
    e.v.pc_src = 1'b1; e.m.pc_src = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_trap();
    exp_t e = e_idle();
    e.v.halted = 1'b1;
    return e;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    exp_t e;
    reset = 1'b1; mem_ready = 1'b1;
    exp_q.push_back(e_reset());
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ((obs & e.m) !== (e.v & e.m)) begin
      n_bad++; $display("FAIL reset_cycle: got %h need %h mask %h", obs, e.v, e.m);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    exp_q.push_back(e_fetch(1'b0));
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ((obs & e.m) !== (e.v & e.m)) begin
      n_bad++; $display("FAIL reset_to_fetch: got %h need %h mask %h", obs, e.v, e.m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    exp_t tab[$];
    logic rdy[$];
    exp_t e;
    set_instr(7'h33, 3'b000, 1'b0); zero_flag = 1'b0;
    tab = '{e_fetch(1'b1), e_decode(), e_exec(1'b0, A_ADD), e_wb(2'b00)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1};
    foreach (tab[i]) begin
      mem_ready = rdy[i];
      exp_q.push_back(tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL add cyc%0d: got %h need %h mask %h", i, obs, e.v, e.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    exp_t tab[$];
    logic rdy[$];
    exp_t e;
    set_instr(7'h03, 3'b010, 1'b0);
    tab = '{e_fetch(1'b0), e_fetch(1'b0), e_fetch(1'b1), e_decode(), e_exec(1'b1, A_ADD),
            e_mem(1'b0, 1'b0), e_mem(1'b0, 1'b0), e_mem(1'b0, 1'b0), e_mem(1'b0, 1'b1),
            e_wb(2'b01)};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    foreach (tab[i]) begin
      mem_ready = rdy[i];
      exp_q.push_back(tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL load_wait cyc%0d: got %h need %h mask %h", i, obs, e.v, e.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    exp_t tab[$];
    logic rdy[$];
    exp_t e;
    set_instr(7'h23, 3'b010, 1'b0);
    tab = '{e_fetch(1'b1), e_decode(), e_exec(1'b1, A_ADD), e_mem(1'b1, 1'b0),
            e_mem(1'b1, 1'b1), e_fetch(1'b0)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    foreach (tab[i]) begin
      mem_ready = rdy[i];
      exp_q.push_back(tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL store cyc%0d: got %h need %h mask %h", i, obs, e.v, e.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s[$]  = '{3'b001, 3'b101, 3'b000, 3'b110, 3'b100};
    logic       zs[$]   = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
    logic [3:0] alus[$] = '{A_SUB,  A_SLT,  A_SUB,  A_SLTU, A_SLT};
    logic       tks[$]  = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    exp_t e;
    foreach (f3s[k]) begin
      exp_t tab[$];
      set_instr(7'h63, f3s[k], 1'b0);
      zero_flag = zs[k];
      mem_ready = 1'b1;
      tab = '{e_fetch(1'b1), e_decode(), e_branch(alus[k], tks[k])};
      foreach (tab[i]) begin
        exp_q.push_back(tab[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          n_bad++;
          $display("FAIL branch f3=%0d z=%0d cyc%0d: got %h need %h mask %h",
                   f3s[k], zs[k], i, obs, e.v, e.m);
        end
        @(posedge clk); #1;
      end
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_upper_and_jumps();
    logic [6:0] ops[$] = '{7'h6F, 7'h67, 7'h37, 7'h17};
    exp_t e;
    mem_ready = 1'b1;
    foreach (ops[k]) begin
      exp_t tab[$];
      set_instr(ops[k], 3'b000, 1'b0);
      case (k)
        0:       tab = '{e_fetch(1'b1), e_decode(), e_jump()};
        1:       tab = '{e_fetch(1'b1), e_decode(), e_exec(1'b1, A_ADD), e_jump()};
        2:       tab = '{e_fetch(1'b1), e_decode(), e_wb(2'b11)};
        default: tab = '{e_fetch(1'b1), e_decode(), e_wb(2'b00)};
      endcase
      foreach (tab[i]) begin
        exp_q.push_back(tab[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          n_bad++;
          $display("FAIL op%02h cyc%0d: got %h need %h mask %h", ops[k], i, obs, e.v, e.m);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops[$]  = '{7'h13,  7'h13,  7'h33,  7'h13,  7'h33,  7'h13};
    logic [2:0] f3s[$]  = '{3'b101, 3'b000, 3'b000, 3'b101, 3'b111, 3'b011};
    logic       f7s[$]  = '{1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
    logic [3:0] alus[$] = '{A_SRA,  A_ADD,  A_SUB,  A_SRL,  A_AND,  A_SLTU};
    exp_t e;
    mem_ready = 1'b1;
    foreach (ops[k]) begin
      exp_t tab[$];
      set_instr(ops[k], f3s[k], f7s[k]);
      tab = '{e_fetch(1'b1), e_decode(), e_exec(ops[k] == 7'h13, alus[k]), e_wb(2'b00)};
      foreach (tab[i]) begin
        exp_q.push_back(tab[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          n_bad++;
          $display("FAIL alu op%02h f3=%0d f7b5=%0d cyc%0d: got %h need %h mask %h",
                   ops[k], f3s[k], f7s[k], i, obs, e.v, e.m);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_trap(input logic [6:0] op, input logic [2:0] f3, input string name);
    exp_t tab[$];
    exp_t e;
    set_instr(op, f3, 1'b0);
    tab.push_back(e_fetch(1'b1));
    tab.push_back(e_decode());
    for (int j = 0; j < 10; j++) tab.push_back(e_trap());
    foreach (tab[i]) begin
      mem_ready = (i < 2) ? 1'b1 : 1'(i % 2);
      exp_q.push_back(tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL trap_%s cyc%0d: got %h need %h mask %h", name, i, obs, e.v, e.m);
      end
      if (i == 1) begin
        n_cmp++;
        if (instr_retired2 !== 1'b1) begin
          n_bad++; $display("FAIL nop_%s_retire: got %b need 1", name, instr_retired2);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({mem_req2, halted2} !== 2'b10) begin
          n_bad++; $display("FAIL nop_%s_refetch: got req/halt %b%b need 10", name, mem_req2, halted2);
        end
      end
      @(posedge clk); #1;
    end
    // Only reset leaves the trap
    reset = 1'b1;
    exp_q.push_back(e_reset());
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ((obs & e.m) !== (e.v & e.m)) begin
      n_bad++; $display("FAIL trap_%s_reset: got %h need %h mask %h", name, obs, e.v, e.m);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_q.push_back(e_fetch(1'b0));
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ((obs & e.m) !== (e.v & e.m)) begin
      n_bad++; $display("FAIL trap_%s_refetch: got %h need %h mask %h", name, obs, e.v, e.m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_memwr();
    exp_t tab[$];
    logic rdy[$];
    logic rst[$];
    exp_t e;
    set_instr(7'h23, 3'b010, 1'b0);
    tab = '{e_fetch(1'b1), e_decode(), e_exec(1'b1, A_ADD), e_mem(1'b1, 1'b0), e_mem(1'b1, 1'b0),
            e_reset(), e_fetch(1'b0), e_fetch(1'b1), e_decode(), e_exec(1'b1, A_ADD),
            e_mem(1'b1, 1'b1), e_fetch(1'b0)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (tab[i]) begin
      mem_ready = rdy[i];
      reset = rst[i];
      exp_q.push_back(tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL reset_memwr cyc%0d: got %h need %h mask %h", i, obs, e.v, e.m);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero_flag = 1'b0;
    set_instr(7'h13, 3'b000, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_branch();
    test_upper_and_jumps();
    test_alu_decode();
    test_trap(7'h00, 3'b000, "op00");
    test_trap(7'h63, 3'b010, "br010");
    test_reset_in_memwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
